// File: rtl/mem_access_stage_pkg.sv
// Shared pipeline definitions for the memory-access stage: FSM encoding,
// default access timeout and the captured-operation / writeback records.
package mem_access_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  localparam int unsigned WAIT_LIMIT_DEFAULT = 15;
  localparam int unsigned WAIT_CNT_W         = 4;

  typedef struct packed {
    logic        we;
    logic        reg_write;
    logic        mem_to_reg;
    logic [4:0]  rd;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_op_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic [31:0] alu_result;
    logic [4:0]  rd;
  } wb_ctl_t;

endpackage

// File: rtl/mem_access_stage_mem_wb.sv
// MEM/WB pipeline register; read data only updates when a load completes.
module mem_wb_register
  import mem_access_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  wb_ctl_t     wb_nxt,
  input  logic        rdata_we,
  input  logic [31:0] rdata_nxt,
  output logic        RegWrite_out,
  output logic        MemToReg_out,
  output logic [31:0] read_data_out,
  output logic [31:0] alu_result_out,
  output logic [4:0]  rd_out
);

  wb_ctl_t     wb_d, wb_q;
  logic [31:0] rdata_d, rdata_q;

  always_comb begin
    wb_d    = wb_nxt;
    rdata_d = rdata_q;
    if (rdata_we) rdata_d = rdata_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_q    <= '0;
      rdata_q <= '0;
    end else begin
      wb_q    <= wb_d;
      rdata_q <= rdata_d;
    end
  end

  assign RegWrite_out   = wb_q.reg_write;
  assign MemToReg_out   = wb_q.mem_to_reg;
  assign alu_result_out = wb_q.alu_result;
  assign rd_out         = wb_q.rd;
  assign read_data_out  = rdata_q;

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: captures a load/store, runs the data-memory
// handshake with timeout, resolves branches and feeds the MEM/WB register.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = WAIT_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWrite_in,
  input  logic        MemToReg_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        Branch_in,
  input  logic        Jump_in,
  input  logic        zero_in,
  input  logic [31:0] branch_target_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] write_data_in,
  input  logic [4:0]  rd_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        pc_src,
  output logic [31:0] pc_target,
  output logic        flush,
  output logic        stall,
  output logic        bus_error,
  output logic        RegWrite_out,
  output logic        MemToReg_out,
  output logic [31:0] read_data_out,
  output logic [31:0] alu_result_out,
  output logic [4:0]  rd_out
);

  localparam logic [WAIT_CNT_W-1:0] LIMIT = WAIT_CNT_W'(WAIT_LIMIT);

  mem_state_t            state_d, state_q;
  logic [WAIT_CNT_W-1:0] cnt_d, cnt_q;
  mem_op_t               op_d, op_q;
  wb_ctl_t               wb_nxt, wb_cap;
  logic                  rdata_we;
  logic                  lim_hit;

  assign lim_hit = (cnt_q == LIMIT);
  assign wb_cap  = '{reg_write: op_q.reg_write, mem_to_reg: op_q.mem_to_reg,
                     alu_result: op_q.addr, rd: op_q.rd};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = op_q.addr;
    dmem_wdata = op_q.wdata;
    stall      = 1'b0;
    bus_error  = 1'b0;
    pc_src     = 1'b0;
    rdata_we   = 1'b0;
    wb_nxt     = '{reg_write: RegWrite_in, mem_to_reg: MemToReg_in,
                   alu_result: alu_result_in, rd: rd_in};
    case (state_q)
      IDLE: begin
        pc_src = (Branch_in & zero_in) | Jump_in;
        if (MemRead_in | MemWrite_in) begin
          op_d    = '{we: MemWrite_in, reg_write: RegWrite_in, mem_to_reg: MemToReg_in,
                      rd: rd_in, addr: alu_result_in, wdata: write_data_in};
          cnt_d   = '0;
          state_d = REQ;
          stall   = 1'b1;
          wb_nxt  = '0;
        end
      end
      REQ: begin
        // Request is withdrawn in the limit cycle, so a late grant there cannot complete.
        dmem_req = !lim_hit;
        dmem_we  = dmem_req & op_q.we;
        cnt_d    = cnt_q + 1'b1;
        wb_nxt   = '0;
        if (dmem_req && dmem_gnt) begin
          if (op_q.we) begin
            state_d = IDLE;
            wb_nxt  = wb_cap;
          end else begin
            state_d = RESP;
            stall   = 1'b1;
          end
        end else if (lim_hit) begin
          bus_error = 1'b1;
          state_d   = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      RESP: begin
        cnt_d  = cnt_q + 1'b1;
        wb_nxt = '0;
        if (dmem_rvalid) begin
          state_d  = IDLE;
          wb_nxt   = wb_cap;
          rdata_we = 1'b1;
        end else if (lim_hit) begin
          bus_error = 1'b1;
          state_d   = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  assign flush     = pc_src;
  assign pc_target = branch_target_in;

  mem_wb_register u_mem_wb (
    .clk            (clk),
    .reset          (reset),
    .wb_nxt         (wb_nxt),
    .rdata_we       (rdata_we),
    .rdata_nxt      (dmem_rdata),
    .RegWrite_out   (RegWrite_out),
    .MemToReg_out   (MemToReg_out),
    .read_data_out  (read_data_out),
    .alu_result_out (alu_result_out),
    .rd_out         (rd_out)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (WAIT_LIMIT=4).
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWrite_in, MemToReg_in, MemRead_in, MemWrite_in;
  logic        Branch_in, Jump_in, zero_in;
  logic [31:0] branch_target_in, alu_result_in, write_data_in;
  logic [4:0]  rd_in;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        pc_src, flush, stall, bus_error;
  logic [31:0] pc_target;
  logic        RegWrite_out, MemToReg_out;
  logic [31:0] read_data_out, alu_result_out;
  logic [4:0]  rd_out;

  int n_tests = 0;
  int n_fail  = 0;
  int stall_cnt;
  int req_cnt;

  always #5 clk = ~clk;

  mem_access_stage #(.WAIT_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .RegWrite_in(RegWrite_in), .MemToReg_in(MemToReg_in),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .Branch_in(Branch_in), .Jump_in(Jump_in), .zero_in(zero_in),
    .branch_target_in(branch_target_in), .alu_result_in(alu_result_in),
    .write_data_in(write_data_in), .rd_in(rd_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .pc_src(pc_src), .pc_target(pc_target),
    .flush(flush), .stall(stall), .bus_error(bus_error),
    .RegWrite_out(RegWrite_out), .MemToReg_out(MemToReg_out),
    .read_data_out(read_data_out), .alu_result_out(alu_result_out),
    .rd_out(rd_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_in();
    RegWrite_in = 0; MemToReg_in = 0; MemRead_in = 0; MemWrite_in = 0;
    Branch_in = 0; Jump_in = 0; zero_in = 0;
    branch_target_in = '0; alu_result_in = '0; write_data_in = '0; rd_in = '0;
    dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = '0;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled before the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_in();
    reset = 1;
    tick(); tick();
    reset = 0;
    #1;
    chk("rst_regwrite", RegWrite_out, 0);
    chk("rst_rd", rd_out, 0);
    chk("rst_rdata", read_data_out, 0);
    chk("rst_alu", alu_result_out, 0);
    chk("rst_stall", stall, 0);
    chk("rst_req", dmem_req, 0);

    // ALU pass-through
    tick();
    alu_result_in = 32'h0000_00AA; rd_in = 5; RegWrite_in = 1;
    #1 chk("alu_stall", stall, 0);
    tick();
    clear_in();
    chk("alu_regwrite", RegWrite_out, 1);
    chk("alu_rd", rd_out, 5);
    chk("alu_result", alu_result_out, 32'hAA);

    // Branch resolution
    Branch_in = 1; zero_in = 1; branch_target_in = 32'h40;
    #1;
    chk("br_pc_src", pc_src, 1);
    chk("br_flush", flush, 1);
    chk("br_target", pc_target, 32'h40);
    zero_in = 0;
    #1 chk("br_not_taken", pc_src, 0);
    tick();
    clear_in();

    // Load: two REQ cycles without grant, grant on third, rvalid next cycle
    stall_cnt = 0;
    MemRead_in = 1; alu_result_in = 32'h100; rd_in = 7; RegWrite_in = 1; MemToReg_in = 1;
    #1 stall_cnt += int'(stall);
    tick();
    clear_in();
    alu_result_in = 32'hFFFF_FFFF; MemWrite_in = 1; rd_in = 31;
    #1;
    chk("ld_req", dmem_req, 1);
    chk("ld_addr", dmem_addr, 32'h100);
    chk("ld_we", dmem_we, 0);
    chk("ld_bubble0", RegWrite_out, 0);
    chk("ld_bubble0_rd", rd_out, 0);
    stall_cnt += int'(stall);
    tick();
    #1;
    chk("ld_req2", dmem_req, 1);
    chk("ld_addr_held", dmem_addr, 32'h100);
    chk("ld_bubble1", RegWrite_out, 0);
    stall_cnt += int'(stall);
    tick();
    dmem_gnt = 1; dmem_rvalid = 1; dmem_rdata = 32'h0000_0BAD;
    #1 stall_cnt += int'(stall);
    tick();
    clear_in();
    #1;
    chk("ld_req_after_gnt", dmem_req, 0);
    chk("ld_rdata_not_early", read_data_out, 0);
    dmem_rvalid = 1; dmem_rdata = 32'hDEAD_BEEF;
    #1 chk("ld_stall_done", stall, 0);
    stall_cnt += int'(stall);
    tick();
    clear_in();
    chk("ld_stall_cycles", stall_cnt, 4);
    chk("ld_rdata", read_data_out, 32'hDEAD_BEEF);
    chk("ld_rd", rd_out, 7);
    chk("ld_regwrite", RegWrite_out, 1);
    chk("ld_memtoreg", MemToReg_out, 1);
    chk("ld_alu", alu_result_out, 32'h100);

    // Store granted in the first REQ cycle
    stall_cnt = 0;
    MemWrite_in = 1; alu_result_in = 32'h200; write_data_in = 32'h1234;
    #1 stall_cnt += int'(stall);
    tick();
    clear_in();
    dmem_gnt = 1;
    #1;
    chk("st_req", dmem_req, 1);
    chk("st_we", dmem_we, 1);
    chk("st_wdata", dmem_wdata, 32'h1234);
    chk("st_addr", dmem_addr, 32'h200);
    stall_cnt += int'(stall);
    tick();
    dmem_gnt = 0;
    #1;
    chk("st_stall_cycles", stall_cnt, 1);
    chk("st_regwrite", RegWrite_out, 0);
    chk("st_req_after_gnt", dmem_req, 0);
    chk("st_rdata_kept", read_data_out, 32'hDEAD_BEEF);

    // Load with grant withheld: abort after four REQ cycles
    req_cnt = 0;
    MemRead_in = 1; alu_result_in = 32'h300; rd_in = 9; RegWrite_in = 1;
    tick();
    clear_in();
    for (int i = 0; i < 4; i++) begin
      #1;
      req_cnt += int'(dmem_req);
      chk("to_stall", stall, 1);
      chk("to_no_err", bus_error, 0);
      tick();
    end
    #1;
    chk("to_req_cycles", req_cnt, 4);
    chk("to_bus_error", bus_error, 1);
    chk("to_req_drop", dmem_req, 0);
    chk("to_stall_rel", stall, 0);
    tick();
    #1;
    chk("to_err_pulse", bus_error, 0);
    chk("to_bubble_rw", RegWrite_out, 0);
    chk("to_bubble_rd", rd_out, 0);
    chk("to_idle_req", dmem_req, 0);
    chk("to_idle_stall", stall, 0);

    // Reset while waiting for read response
    MemRead_in = 1; alu_result_in = 32'h400; rd_in = 3; RegWrite_in = 1;
    tick();
    clear_in();
    dmem_gnt = 1;
    tick();
    dmem_gnt = 0;
    #1 chk("rr_resp_stall", stall, 1);
    reset = 1;
    tick();
    reset = 0;
    #1;
    chk("rr_stall", stall, 0);
    chk("rr_req", dmem_req, 0);
    chk("rr_rdata", read_data_out, 0);
    chk("rr_regwrite", RegWrite_out, 0);
    chk("rr_alu", alu_result_out, 0);
    chk("rr_err", bus_error, 0);
    dmem_rvalid = 1; dmem_rdata = 32'h5555_5555;
    #1 chk("rr_late_stall", stall, 0);
    tick();
    clear_in();
    chk("rr_late_rdata", read_data_out, 0);
    chk("rr_late_rw", RegWrite_out, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter WAIT_LIMIT, default 15, SHALL set the maximum cycles an access may spend in REQ+RESP before abort (range 2..15).
REQ-002 Port clk  input  1  clock; all state SHALL update on the rising edge only.
REQ-003 Port reset  input  1  reset, synchronous, active-high; clock clk.
REQ-004 Ports RegWrite_in, MemToReg_in, MemRead_in, MemWrite_in, Branch_in, Jump_in, zero_in  input  1 each  EX/MEM pipeline register outputs.
REQ-005 Ports branch_target_in, alu_result_in, write_data_in  input  32 each; rd_in  input  5  EX/MEM pipeline register outputs.
REQ-006 Ports dmem_req  output 1; dmem_we  output 1; dmem_addr  output 32; dmem_wdata  output 32  data-memory request channel.
REQ-007 Ports dmem_gnt  input 1; dmem_rvalid  input 1; dmem_rdata  input 32  data-memory grant and read-response channel.
REQ-008 Ports pc_src  output 1; pc_target  output 32; flush  output 1  branch resolution to fetch and hazard logic.
REQ-009 Port stall  output 1  freeze request to all upstream stages.
REQ-010 Port bus_error  output 1  one-cycle pulse on access timeout.
REQ-011 Ports RegWrite_out, MemToReg_out  output 1 each; read_data_out, alu_result_out  output 32 each; rd_out  output 5  MEM/WB register.

Function
REQ-012 FSM states SHALL be IDLE, REQ and RESP.
REQ-013 IDLE with MemRead_in|MemWrite_in=1: capture alu_result_in, write_data_in, rd_in, RegWrite_in, MemToReg_in and op type into internal registers; go to REQ; stall=1.
REQ-014 While in REQ or RESP, all EX/MEM inputs SHALL be ignored; only the captured copy is used.
REQ-015 REQ: dmem_req=1, dmem_we=captured write flag, dmem_addr/dmem_wdata=captured values, all held stable until dmem_gnt=1.
REQ-016 REQ with dmem_gnt=1: write -> IDLE; read -> RESP; dmem_req SHALL be 0 in the cycle after gnt.
REQ-017 RESP with dmem_rvalid=1: read_data_out<=dmem_rdata, go to IDLE; dmem_rvalid outside RESP SHALL be ignored.
REQ-018 stall = (state IDLE and memory op present) or (state REQ/RESP and not completing); completing = gnt on write in REQ, or rvalid in RESP; stall=0 in the completing cycle.
REQ-019 MEM/WB SHALL be loaded with the captured instruction at the completing edge; every other busy cycle it SHALL load a bubble (RegWrite_out=0, rd_out=0, MemToReg_out=0).
REQ-020 IDLE with no memory op: MEM/WB SHALL load RegWrite_in, MemToReg_in, alu_result_in, rd_in with one-cycle latency; read_data_out holds its value.
REQ-021 pc_src = (Branch_in&zero_in)|Jump_in, combinational, in IDLE only; 0 in REQ/RESP; flush=pc_src; pc_target=branch_target_in.
REQ-022 Wait counter (4 bits) SHALL clear on IDLE->REQ and increment each REQ/RESP cycle; on reaching WAIT_LIMIT without completion: bus_error=1 one cycle, dmem_req=0, return to IDLE, load bubble into MEM/WB, stall=0 that cycle.
REQ-023 dmem_gnt and dmem_rvalid in the same REQ cycle SHALL be treated as gnt only.
REQ-024 Back-to-back memory ops: a new op SHALL be captured no earlier than the cycle after return to IDLE.

Reset
REQ-025 Reset SHALL force state=IDLE, counter=0, and every registered output (MEM/WB fields, read_data_out) to 0.
REQ-026 Reset asserted mid-access SHALL abandon it: dmem_req=0 and stall=0 from the following cycle, no MEM/WB write, no bus_error.

Structure
REQ-027 FSM state encoding and the default WAIT_LIMIT SHALL live in the shared pipeline package.
REQ-028 The MEM/WB register SHALL be a separate sub-module mem_wb_register; FSM, counter and branch logic remain in mem_access_stage.

Verification
REQ-029 ALU op alu_result_in=0x0000_00AA, rd_in=5, RegWrite_in=1 -> next cycle RegWrite_out=1, rd_out=5, alu_result_out=0xAA, stall never 1.
REQ-030 Load addr 0x100, gnt after 2 cycles, rvalid 1 cycle later with 0xDEADBEEF -> stall 4 cycles, read_data_out=0xDEADBEEF, rd_out correct, preceding MEM/WB entries are bubbles.
REQ-031 Store addr 0x200, data 0x1234, gnt in first REQ cycle -> dmem_we=1, dmem_wdata=0x1234, stall 1 cycle, RegWrite_out=0.
REQ-032 Branch_in=1, zero_in=1, branch_target_in=0x40 -> pc_src=1, flush=1, pc_target=0x40 same cycle; zero_in=0 -> pc_src=0.
REQ-033 Load, gnt withheld, WAIT_LIMIT=4 -> bus_error pulses after 4 REQ cycles, dmem_req drops, bubble written, FSM IDLE.
REQ-034 Reset during RESP -> next cycle IDLE, stall=0, all outputs 0; subsequent late rvalid ignored.
